// File: rtl/sat_acc_pkg.sv
// Shared types and constants for the saturating frame accumulator.
// Saturation limits are computed from the sample width.
package sat_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    // Largest value representable in n-bit two's complement.
    function automatic longint sat_max(input int unsigned n);
        return (longint'(1) <<< (n - 1)) - longint'(1);
    endfunction

    // Smallest value representable in n-bit two's complement.
    function automatic longint sat_min(input int unsigned n);
        return -(longint'(1) <<< (n - 1));
    endfunction

endpackage

// File: rtl/n_bit_adder.sv
// Plain N-bit ripple adder with carry-in.
// Overflow handling belongs to the caller.
module n_bit_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         cin,
    output logic [N-1:0] S
);

    assign S = A + B + {{(N-1){1'b0}}, cin};

endmodule

// File: rtl/sat_accumulator.sv
// Sums LEN signed samples per frame with saturation, then presents the result
// on a valid/ready output until it is taken.
module sat_accumulator
    import sat_acc_pkg::*;
#(
    parameter int N   = 8,
    parameter int LEN = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_ovf
);

    localparam int CW = $clog2(LEN);
    localparam logic [N-1:0]  SAT_HI = N'(sat_max(N));
    localparam logic [N-1:0]  SAT_LO = N'(sat_min(N));
    localparam logic [CW-1:0] LAST   = CW'(LEN - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic [N-1:0]  sum;
    logic          sat_hit;
    logic [N-1:0]  sat_val;

    n_bit_adder #(.N(N)) u_adder (
        .A   (acc_q),
        .B   (in_data),
        .cin (1'b0),
        .S   (sum)
    );

    // Overflow only when both operands share a sign the result does not.
    assign sat_hit = (acc_q[N-1] == in_data[N-1]) && (sum[N-1] != acc_q[N-1]);
    assign sat_val = sat_hit ? (acc_q[N-1] ? SAT_LO : SAT_HI) : sum;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    acc_d = sat_val;
                    ovf_d = ovf_q | sat_hit;
                    if (count_q == LAST) begin
                        count_d = '0;
                        state_d = OUT;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
        // Abort wins over any handshake in the same cycle.
        if (clr) begin
            state_d = ACCUM;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUT);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sat_accumulator.sv
// Scoreboard bench for sat_accumulator (N=8, LEN=4): stimulus pushes expected
// frame results, a monitor pops and compares on each output handshake.
module tb_sat_accumulator;

    logic               clk = 1'b0;
    logic               rstn, clr, in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic        [7:0]  in_data;
    logic        [7:0]  out_sum;

    typedef struct {
        logic signed [7:0] sum;
        logic              ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    sat_accumulator #(.N(8), .LEN(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until the block takes it.
    task automatic send(input int v);
        int   n;
        logic took;
        n        = 0;
        took     = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'(v);
        while (!took && n < 20) begin
            took = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("send_accepted", {31'd0, took}, 32'd1);
    endtask

    task automatic expect_frame(input int s, input logic o);
        exp_t e;
        e.sum = 8'(s);
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    // Monitor: compare on every output handshake.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum %0d ovf %0d, expected none",
                         $signed(out_sum), out_ovf);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (out_sum !== e.sum || out_ovf !== e.ovf) begin
                    errors++;
                    $display("FAIL frame_result: got sum %0d ovf %0d, expected sum %0d ovf %0d",
                             $signed(out_sum), out_ovf, e.sum, e.ovf);
                end
            end
        end
    end

    initial begin
        int   racc;
        logic rovf;
        int   smp;
        logic [7:0] held_sum;
        logic       held_ovf;

        rstn      = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) tick();
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_sum", {24'd0, out_sum}, 32'd0);
        chk("reset_out_ovf", {31'd0, out_ovf}, 32'd0);
        rstn = 1'b1;
        tick();

        // Basic frame with latency check.
        expect_frame(32, 1'b0);
        send(5); send(10); send(-3);
        chk("basic_no_early_valid", {31'd0, out_valid}, 32'd0);
        send(20);
        chk("basic_valid_latency", {31'd0, out_valid}, 32'd1);
        chk("basic_in_ready_low", {31'd0, in_ready}, 32'd0);

        expect_frame(87, 1'b1);
        send(100); send(100); send(-50); send(10);

        expect_frame(-128, 1'b1);
        send(-100); send(-100); send(-1); send(0);
        tick();

        // Backpressure, with a junk sample offered while the result is held.
        out_ready = 1'b0;
        expect_frame(125, 1'b1);
        send(120); send(10); send(-5); send(3);
        held_sum = out_sum;
        held_ovf = out_ovf;
        in_valid = 1'b1;
        in_data  = 8'd99;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            chk("bp_sum_stable", {24'd0, out_sum}, 32'd125);
            chk("bp_ovf_stable", {31'd0, out_ovf}, 32'd1);
            tick();
        end
        chk("bp_sum_unchanged", {24'd0, out_sum}, {24'd0, held_sum});
        chk("bp_ovf_unchanged", {31'd0, out_ovf}, {31'd0, held_ovf});
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_in_ready_after_hs", {31'd0, in_ready}, 32'd1);
        chk("bp_valid_dropped", {31'd0, out_valid}, 32'd0);

        // Abort mid-frame with clr colliding with a sample.
        send(7); send(8);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd50;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_sum_cleared", {24'd0, out_sum}, 32'd0);
        chk("clr_in_ready", {31'd0, in_ready}, 32'd1);
        expect_frame(4, 1'b0);
        send(1); send(1); send(1); send(1);
        tick();

        // Same abort through reset.
        send(7); send(8);
        rstn     = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'd50;
        tick();
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_sum", {24'd0, out_sum}, 32'd0);
        chk("midrst_out_ovf", {31'd0, out_ovf}, 32'd0);
        rstn     = 1'b1;
        in_valid = 1'b0;
        expect_frame(4, 1'b0);
        send(1); send(1); send(1); send(1);
        tick();

        // clr discards a result waiting in OUT.
        out_ready = 1'b0;
        send(9); send(9); send(9); send(9);
        chk("discard_valid_before", {31'd0, out_valid}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("discard_valid_after", {31'd0, out_valid}, 32'd0);
        chk("discard_sum_after", {24'd0, out_sum}, 32'd0);
        out_ready = 1'b1;

        // Bubbled random frames against a saturating reference.
        for (int f = 0; f < 8; f++) begin
            int vals[4];
            racc = 0;
            rovf = 1'b0;
            for (int k = 0; k < 4; k++) begin
                vals[k] = int'($urandom_range(254, 0)) - 127;
                racc += vals[k];
                if (racc > 127) begin
                    racc = 127;
                    rovf = 1'b1;
                end else if (racc < -128) begin
                    racc = -128;
                    rovf = 1'b1;
                end
            end
            expect_frame(racc, rovf);
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(3, 0)) tick();
                smp = vals[k];
                send(smp);
            end
        end

        repeat (5) tick();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
